bbc_csr_boot_harness: RTL

- Parametrised successor to the fixed-tie-off top-level harness around bbc_micro_with_rams.
- After reset it plays a boot script of NUM_WRITES CSR writes into the micro's CSR request/response pair, with a per-write ack timeout.
- It monitors display_sram_write traffic and drives the board LEDs from a selectable view.
- It sits between the board top (clock, reset, LEDs) and the micro; host SRAM request is still tied off by the top.

---
 rtl/bbc_csr_boot_harness_if.sv | 43 ++++
 rtl/bbc_csr_boot_harness.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bbc_csr_boot_harness_if.sv
// CSR request/response pair plus display SRAM write monitor bus between the
// boot harness (master) and the micro (slave).
interface bbc_csr_boot_harness_if;
    logic        csr_request__valid;
    logic        csr_request__read_not_write;
    logic [15:0] csr_request__select;
    logic [15:0] csr_request__address;
    logic [31:0] csr_request__data;
    logic        csr_response__ack;
    logic        csr_response__read_data_valid;
    logic [31:0] csr_response__read_data;
    logic        display_sram_write__enable;
    logic [47:0] display_sram_write__data;
    logic [15:0] display_sram_write__address;

    modport master (
        output csr_request__valid,
        output csr_request__read_not_write,
        output csr_request__select,
        output csr_request__address,
        output csr_request__data,
        input  csr_response__ack,
        input  csr_response__read_data_valid,
        input  csr_response__read_data,
        input  display_sram_write__enable,
        input  display_sram_write__data,
        input  display_sram_write__address
    );

    modport slave (
        input  csr_request__valid,
        input  csr_request__read_not_write,
        input  csr_request__select,
        input  csr_request__address,
        input  csr_request__data,
        output csr_response__ack,
        output csr_response__read_data_valid,
        output csr_response__read_data,
        output display_sram_write__enable,
        output display_sram_write__data,
        output display_sram_write__address
    );
endinterface

// File: rtl/bbc_csr_boot_harness.sv
// Boot harness: replays a CSR write script after reset/restart with a per-write
// ack timeout, and monitors display SRAM writes to drive the board LEDs.
module bbc_csr_boot_harness #(
    parameter int unsigned NUM_WRITES = 4,
    parameter logic [15:0] CSR_SELECT = 16'h0000,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned LED_MODE   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WRITES*48-1:0]   boot_script,
    input  logic                       restart,
    bbc_csr_boot_harness_if.master     bus,
    output logic                       boot_done,
    output logic                       boot_error,
    output logic [7:0]                 leds
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [5:0]  LAST_INDEX   = 6'(NUM_WRITES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [5:0]  index;
    logic [15:0] wait_count;
    logic [15:0] disp_count;
    logic [7:0]  last_byte;
    logic [47:0] entry;
    logic        issuing;
    logic        unused_inputs;

    always_comb begin
        entry = '0;
        for (int unsigned i = 0; i < NUM_WRITES; i++) begin
            if (index == 6'(i)) entry = boot_script[48*i +: 48];
        end
    end

    // Address/data are only presented while the request is valid, so they
    // read as zero in reset and in every non-issuing state.
    assign issuing                         = (state == ST_ISSUE);
    assign bus.csr_request__valid          = issuing;
    assign bus.csr_request__read_not_write = 1'b0;
    assign bus.csr_request__select         = CSR_SELECT;
    assign bus.csr_request__address        = issuing ? entry[47:32] : '0;
    assign bus.csr_request__data           = issuing ? entry[31:0]  : '0;

    assign unused_inputs = ^{bus.csr_response__read_data_valid, bus.csr_response__read_data,
                             bus.display_sram_write__address, bus.display_sram_write__data[47:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            wait_count <= '0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_ISSUE;
                    index      <= '0;
                    wait_count <= '0;
                end
                ST_ISSUE: begin
                    // An ack on the final wait cycle still wins over the timeout.
                    if (bus.csr_response__ack) begin
                        wait_count <= '0;
                        if (index == LAST_INDEX) begin
                            state     <= ST_DONE;
                            boot_done <= 1'b1;
                        end else begin
                            index <= index + 6'd1;
                            state <= ST_GAP;
                        end
                    end else begin
                        wait_count <= wait_count + 16'd1;
                        if (wait_count == TIMEOUT_LAST) begin
                            state      <= ST_ERROR;
                            boot_error <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    state      <= ST_ISSUE;
                    wait_count <= '0;
                end
                ST_DONE, ST_ERROR: begin
                    if (restart) begin
                        state      <= ST_ISSUE;
                        index      <= '0;
                        wait_count <= '0;
                        boot_done  <= 1'b0;
                        boot_error <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_count <= '0;
            last_byte  <= '0;
        end else if (bus.display_sram_write__enable) begin
            disp_count <= disp_count + 16'd1;
            last_byte  <= bus.display_sram_write__data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
        end else begin
            case (LED_MODE)
                1:       leds <= disp_count[7:0];
                2:       leds <= {boot_error, boot_done, index};
                default: leds <= last_byte;
            endcase
        end
    end

endmodule
